// File: rtl/gshare_pkg.sv
// gshare_pkg: default table geometry and the in-flight prediction entry shared by the gshare index unit and its FIFO
package gshare_pkg;
  localparam int ENTRY_NUM = 8192;
  localparam int INDEX_BITS = $clog2(ENTRY_NUM);
  typedef struct packed {
    logic [INDEX_BITS-1:0] index;
    logic pred;
  } gshare_entry_t;
endpackage

// File: rtl/gshare_inflight_fifo.sv
// gshare_inflight_fifo: circular FIFO of in-flight predictions; clk, reset (async low), clear (sync empty), push/push_data, pop/head, count
module gshare_inflight_fifo
  import gshare_pkg::*;
#(
  parameter type entry_t = gshare_entry_t,
  parameter int DEPTH = 8,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          push,
  input  entry_t        push_data,
  input  logic          pop,
  output entry_t        head,
  output logic [CW-1:0] count
);
  entry_t mem [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic do_push, do_pop;
  assign do_push = push & (count != CW'(DEPTH));
  assign do_pop = pop & (count != '0);
  assign head = mem[rd_ptr];
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else if (clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else begin
      wr_ptr <= do_push ? wr_ptr + PW'(1) : wr_ptr;
      rd_ptr <= do_pop ? rd_ptr + PW'(1) : rd_ptr;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  always_ff @(posedge clk)
    if (do_push && !clear) mem[wr_ptr] <= push_data;
endmodule

// File: rtl/gshare_index_unit.sv
// gshare_index_unit: gshare index = pc^spec history, tracks in-flight predictions, repairs history on mispredict/flush and emits registered training (clk, reset async low, fetch_*, resolve_*, flush, update_*, resolve_err)
module gshare_index_unit #(
  parameter int ENTRY_NUM = gshare_pkg::ENTRY_NUM,
  parameter int INDEX_BITS = $clog2(ENTRY_NUM),
  parameter int FIFO_DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  fetch_valid,
  input  logic [31:0]           fetch_pc,
  input  logic                  bht_predict_taken,
  output logic                  fetch_ready,
  output logic [INDEX_BITS-1:0] lookup_index,
  input  logic                  resolve_valid,
  input  logic [31:0]           resolve_pc,
  input  logic                  resolve_taken,
  output logic                  mispredict,
  input  logic                  flush,
  output logic                  update_en,
  output logic [31:0]           update_pc,
  output logic [INDEX_BITS-1:0] update_index,
  output logic                  actual_taken,
  output logic                  resolve_err
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  typedef struct packed {
    logic [INDEX_BITS-1:0] index;
    logic pred;
  } entry_t;
  logic [INDEX_BITS-1:0] spec_ghr, commit_ghr, commit_next;
  logic [CW-1:0] count;
  entry_t head;
  logic empty, pop, push, kill, unused_pc;
  assign lookup_index = fetch_pc[INDEX_BITS+1:2] ^ spec_ghr;
  assign fetch_ready = count != CW'(FIFO_DEPTH);
  assign empty = count == '0;
  assign pop = resolve_valid & ~empty;
  assign mispredict = pop & (resolve_taken != head.pred);
  assign kill = flush | mispredict;
  assign push = fetch_valid & fetch_ready & ~kill;
  // committed history already includes this cycle's resolve, so a repair lands on the post-pop value
  assign commit_next = pop ? {commit_ghr[INDEX_BITS-2:0], resolve_taken} : commit_ghr;
  assign unused_pc = ^{fetch_pc[31:INDEX_BITS+2], fetch_pc[1:0]};
  gshare_inflight_fifo #(
    .entry_t(entry_t),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk(clk),
    .reset(reset),
    .clear(kill),
    .push(push),
    .push_data(entry_t'({lookup_index, bht_predict_taken})),
    .pop(pop),
    .head(head),
    .count(count)
  );
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      spec_ghr <= '0;
      commit_ghr <= '0;
      update_en <= 1'b0;
      update_pc <= '0;
      update_index <= '0;
      actual_taken <= 1'b0;
      resolve_err <= 1'b0;
    end else begin
      commit_ghr <= commit_next;
      spec_ghr <= kill ? commit_next : push ? {spec_ghr[INDEX_BITS-2:0], bht_predict_taken} : spec_ghr;
      update_en <= pop;
      update_pc <= pop ? resolve_pc : update_pc;
      update_index <= pop ? head.index : update_index;
      actual_taken <= pop ? resolve_taken : actual_taken;
      resolve_err <= resolve_err | (resolve_valid & empty);
    end
endmodule

// File: tb/tb_gshare_index_unit.sv
// tb_gshare_index_unit: directed scoreboard bench for gshare_index_unit
module tb_gshare_index_unit;
  localparam int IB = 13;
  localparam int DEPTH = 8;
  typedef struct packed {
    logic [IB-1:0] index;
    logic pred;
  } ent_t;
  typedef struct packed {
    logic [31:0] pc;
    logic [IB-1:0] index;
    logic taken;
  } upd_t;
  logic clk = 0, reset = 0, fetch_valid = 0, bht_predict_taken = 0;
  logic resolve_valid = 0, resolve_taken = 0, flush = 0;
  logic [31:0] fetch_pc = 0, resolve_pc = 0;
  logic fetch_ready, mispredict, update_en, actual_taken, resolve_err;
  logic [IB-1:0] lookup_index, update_index;
  logic [31:0] update_pc;
  int checks = 0, failures = 0;
  ent_t mq[$];
  upd_t sb[$];
  logic [IB-1:0] m_spec = 0, m_commit = 0, saved;
  logic m_err = 0;
  gshare_index_unit dut (
    .clk(clk), .reset(reset), .fetch_valid(fetch_valid), .fetch_pc(fetch_pc),
    .bht_predict_taken(bht_predict_taken), .fetch_ready(fetch_ready), .lookup_index(lookup_index),
    .resolve_valid(resolve_valid), .resolve_pc(resolve_pc), .resolve_taken(resolve_taken),
    .mispredict(mispredict), .flush(flush), .update_en(update_en), .update_pc(update_pc),
    .update_index(update_index), .actual_taken(actual_taken), .resolve_err(resolve_err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic cyc();
    logic pop, misp, kill, push;
    logic [IB-1:0] idx;
    upd_t e;
    #1;
    idx = fetch_pc[IB+1:2] ^ m_spec;
    pop = resolve_valid && mq.size() > 0;
    misp = 0;
    if (pop) misp = resolve_taken != mq[0].pred;
    chk("lookup_index", lookup_index, idx);
    chk("mispredict", mispredict, misp);
    chk("fetch_ready", fetch_ready, mq.size() < DEPTH);
    kill = flush || misp;
    push = fetch_valid && mq.size() < DEPTH && !kill;
    if (pop) begin
      sb.push_back(upd_t'{resolve_pc, mq[0].index, resolve_taken});
      void'(mq.pop_front());
      m_commit = {m_commit[IB-2:0], resolve_taken};
    end
    if (resolve_valid && !pop) m_err = 1;
    if (kill) begin
      mq.delete();
      m_spec = m_commit;
    end else if (push) begin
      mq.push_back(ent_t'{idx, bht_predict_taken});
      m_spec = {m_spec[IB-2:0], bht_predict_taken};
    end
    @(posedge clk);
    #1;
    chk("update_en", update_en, pop);
    if (update_en) begin
      chk("sb_nonempty", sb.size() != 0, 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("update_pc", update_pc, e.pc);
        chk("update_index", update_index, e.index);
        chk("actual_taken", actual_taken, e.taken);
      end
    end
    chk("spec_ghr", dut.spec_ghr, m_spec);
    chk("commit_ghr", dut.commit_ghr, m_commit);
    chk("count", dut.count, mq.size());
    chk("resolve_err", resolve_err, m_err);
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_spec", dut.spec_ghr, 0);
    chk("rst_commit", dut.commit_ghr, 0);
    chk("rst_count", dut.count, 0);
    chk("rst_update_en", update_en, 0);
    chk("rst_update_pc", update_pc, 0);
    chk("rst_update_index", update_index, 0);
    chk("rst_actual", actual_taken, 0);
    chk("rst_err", resolve_err, 0);
    chk("rst_ready", fetch_ready, 1);
    reset = 1;
    fetch_valid = 1; fetch_pc = 32'h100; bht_predict_taken = 1;
    #1 chk("t034_lookup", lookup_index, 32'h040);
    cyc();
    chk("t034_spec", dut.spec_ghr, 1);
    fetch_valid = 0; resolve_valid = 1; resolve_pc = 32'h100; resolve_taken = 1;
    cyc();
    chk("t034_update_index", update_index, 32'h040);
    chk("t034_actual", actual_taken, 1);
    resolve_valid = 0;
    cyc();
    fetch_valid = 1; bht_predict_taken = 1;
    for (int i = 0; i < 3; i++) begin
      fetch_pc = 32'h200 + 32'(4 * i);
      cyc();
    end
    fetch_pc = 32'h300; resolve_valid = 1; resolve_taken = 0; resolve_pc = 32'h200;
    #1 chk("t035_mispredict", mispredict, 1);
    cyc();
    chk("t035_count", dut.count, 0);
    fetch_valid = 0; resolve_valid = 0;
    cyc();
    fetch_valid = 1;
    for (int i = 0; i < DEPTH; i++) begin
      fetch_pc = 32'h400 + 32'(4 * i);
      bht_predict_taken = i[0];
      cyc();
    end
    chk("t036_ready", fetch_ready, 0);
    saved = m_spec;
    fetch_pc = 32'h500; bht_predict_taken = 1;
    cyc();
    chk("t036_spec_hold", dut.spec_ghr, saved);
    resolve_valid = 1; resolve_taken = mq[0].pred; resolve_pc = 32'h400;
    cyc();
    resolve_taken = mq[0].pred; resolve_pc = 32'h404; fetch_pc = 32'h504;
    cyc();
    chk("t036_count_pp", dut.count, 7);
    resolve_valid = 0; fetch_pc = 32'h508;
    cyc();
    chk("t036_count_full", dut.count, 8);
    fetch_valid = 0; resolve_valid = 1;
    for (int i = 0; i < DEPTH; i++) begin
      resolve_taken = mq[0].pred;
      resolve_pc = 32'h700 + 32'(4 * i);
      cyc();
    end
    resolve_valid = 0;
    cyc();
    fetch_valid = 1; bht_predict_taken = 0;
    for (int i = 0; i < 2; i++) begin
      fetch_pc = 32'h600 + 32'(4 * i);
      cyc();
    end
    fetch_valid = 0; flush = 1; resolve_valid = 1; resolve_taken = mq[0].pred; resolve_pc = 32'h600;
    cyc();
    chk("t038_update_en", update_en, 1);
    chk("t038_count", dut.count, 0);
    flush = 0; resolve_valid = 0;
    cyc();
    resolve_valid = 1; resolve_pc = 32'h900;
    cyc();
    chk("t037_err", resolve_err, 1);
    resolve_valid = 0;
    cyc();
    fetch_valid = 1; bht_predict_taken = 1;
    for (int i = 0; i < 5; i++) begin
      fetch_pc = 32'hA00 + 32'(4 * i);
      cyc();
    end
    fetch_valid = 0;
    #2 reset = 0;
    #1;
    chk("t039_count", dut.count, 0);
    chk("t039_spec", dut.spec_ghr, 0);
    chk("t039_commit", dut.commit_ghr, 0);
    chk("t039_update_en", update_en, 0);
    chk("t039_update_pc", update_pc, 0);
    chk("t039_update_index", update_index, 0);
    chk("t039_actual", actual_taken, 0);
    chk("t039_err", resolve_err, 0);
    chk("t039_ready", fetch_ready, 1);
    mq.delete(); m_spec = 0; m_commit = 0; m_err = 0;
    @(posedge clk);
    #1 reset = 1;
    fetch_valid = 1; fetch_pc = 32'h1234; bht_predict_taken = 0;
    cyc();
    fetch_valid = 0; resolve_valid = 1; resolve_taken = 1; resolve_pc = 32'h1234;
    cyc();
    resolve_valid = 0;
    cyc();
    chk("sb_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
